// File: rtl/bus_pkg.sv
// Shared definitions for the register-bus transfer arbiter: widths, FSM state
// encoding and the transfer validity rule.
package bus_pkg;

    localparam int REG_SEL_W = 3;
    localparam int BUS_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LATCH,
        ST_ACK
    } bus_state_e;

    // A move is rejected when it would copy a register onto itself or name a register that is not on the bus.
    function automatic logic xfer_valid(input int src, input int dst, input int num_regs);
        return (src != dst) && (src < num_regs) && (dst < num_regs);
    endfunction

endpackage

// File: rtl/bus_transfer_arbiter_if.sv
// Requester-side and register-file-side signals of the transfer arbiter.
// The arbiter uses the master modport; requesters/register file use slave.
interface bus_transfer_arbiter_if
    import bus_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = REG_SEL_W
);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*SEL_W-1:0] req_src;
    logic [NUM_REQ*SEL_W-1:0] req_dst;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;
    logic [NUM_REGS-1:0]      reg_out_en;
    logic [NUM_REGS-1:0]      reg_in_en;
    logic                     busy;

    modport master (
        input  req, req_src, req_dst,
        output grant, done, err, reg_out_en, reg_in_en, busy
    );

    modport slave (
        output req, req_src, req_dst,
        input  grant, done, err, reg_out_en, reg_in_en, busy
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first active request at or after ptr
// (wrapping) wins. Returns the one-hot winner, its index and a valid flag.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    // NOTE: every output gets a default before the search loop so that no path through the block leaves a value unassigned (no latch).
    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(ptr) + i) % N]) begin
                valid                        = 1'b1;
                winner[(int'(ptr) + i) % N]  = 1'b1;
                idx                          = PTR_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Sequences one register-to-register move at a time on the shared bus:
// source drive (DRIVE), source drive plus destination load (LATCH), then ACK.
module bus_transfer_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8
) (
    input  logic                   bus_arbiter_clock,
    input  logic                   bus_arbiter_reset,
    bus_transfer_arbiter_if.master bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    bus_state_e           state;
    logic [PTR_W-1:0]     ptr;
    logic [REG_SEL_W-1:0] dst_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_REQ-1:0]   err_q;
    logic [NUM_REGS-1:0]  out_en_q;
    logic [NUM_REGS-1:0]  in_en_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_valid;

    logic [REG_SEL_W-1:0] cand_src;
    logic [REG_SEL_W-1:0] cand_dst;
    logic                 cand_ok;
    logic [PTR_W-1:0]     next_ptr;
    logic [NUM_REGS-1:0]  src_dec;
    logic [NUM_REGS-1:0]  dst_dec;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Candidate transfer of the current winner, and the one-hot enables it would need.
    always_comb begin
        cand_src = bus.req_src[int'(pick_idx)*REG_SEL_W +: REG_SEL_W];
        cand_dst = bus.req_dst[int'(pick_idx)*REG_SEL_W +: REG_SEL_W];
        cand_ok  = xfer_valid(int'(cand_src), int'(cand_dst), NUM_REGS);
        next_ptr = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
        src_dec  = '0;
        dst_dec  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            src_dec[i] = (int'(cand_src) == i);
            dst_dec[i] = (int'(dst_q) == i);
        end
    end

    // NOTE: asynchronous reset clears every registered output at once, and all state updates use non-blocking assignments so each register sees pre-edge values.
    always_ff @(posedge bus_arbiter_clock or negedge bus_arbiter_reset) begin
        if (!bus_arbiter_reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            dst_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            out_en_q <= '0;
            in_en_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_onehot;
                        ptr     <= next_ptr;
                        dst_q   <= cand_dst;
                        busy_q  <= 1'b1;
                        if (cand_ok) begin
                            state    <= ST_DRIVE;
                            out_en_q <= src_dec;
                        end else begin
                            // Rejected moves skip straight to ACK and never touch the register enables.
                            state  <= ST_ACK;
                            done_q <= pick_onehot;
                            err_q  <= pick_onehot;
                        end
                    end
                end
                ST_DRIVE: begin
                    state   <= ST_LATCH;
                    in_en_q <= dst_dec;
                end
                ST_LATCH: begin
                    state    <= ST_ACK;
                    out_en_q <= '0;
                    in_en_q  <= '0;
                    done_q   <= grant_q;
                end
                ST_ACK: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.reg_out_en = out_en_q;
    assign bus.reg_in_en  = in_en_q;
    assign bus.busy       = busy_q;

    // Structural invariants of the enable outputs.
    a_grant_onehot0 : assert property (@(posedge bus_arbiter_clock) disable iff (!bus_arbiter_reset)
        $onehot0(grant_q));
    a_out_onehot0 : assert property (@(posedge bus_arbiter_clock) disable iff (!bus_arbiter_reset)
        $onehot0(out_en_q));
    a_in_onehot0 : assert property (@(posedge bus_arbiter_clock) disable iff (!bus_arbiter_reset)
        $onehot0(in_en_q));
    a_in_needs_out : assert property (@(posedge bus_arbiter_clock) disable iff (!bus_arbiter_reset)
        (in_en_q != '0) |-> (out_en_q != '0));

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed plus randomized bench for bus_transfer_arbiter with a transaction-level
// round-robin model and a behavioural register file on the bus enables.
module tb_bus_transfer_arbiter;
    import bus_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 8;
    localparam int W        = REG_SEL_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_transfer_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .SEL_W(W)) bus ();

    bus_transfer_arbiter #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS)) dut (
        .bus_arbiter_clock (clk),
        .bus_arbiter_reset (rst_n),
        .bus               (bus)
    );

    int checks = 0;
    int errors = 0;

    // Register file: whichever register is enabled drives the bus; the loaded one captures on the edge.
    logic [BUS_W-1:0] regs [NUM_REGS];
    logic [BUS_W-1:0] bus_data;
    logic [BUS_W-1:0] cap;

    always_comb begin
        bus_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (bus.reg_out_en[i]) bus_data = bus_data | regs[i];
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = BUS_W'($urandom);
        regs[2] = 16'hA5A5;
        forever begin
            @(posedge clk);
            cap = bus_data;
            for (int i = 0; i < NUM_REGS; i++)
                if (bus.reg_in_en[i]) regs[i] = cap;
        end
    end

    // Requester stimulus and model state.
    logic [NUM_REQ-1:0] req_v;
    int src_v [NUM_REQ];
    int dst_v [NUM_REQ];
    int model_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.req = req_v;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_src[i*W +: W] = W'(src_v[i]);
            bus.req_dst[i*W +: W] = W'(dst_v[i]);
        end
    endtask

    task automatic invariants();
        check("grant_onehot0",  32'($onehot0(bus.grant)), 32'd1);
        check("out_en_onehot0", 32'($onehot0(bus.reg_out_en)), 32'd1);
        check("in_en_onehot0",  32'($onehot0(bus.reg_in_en)), 32'd1);
        check("in_implies_out", 32'((bus.reg_in_en == '0) || (bus.reg_out_en != '0)), 32'd1);
        check("no_same_index",  32'(bus.reg_in_en & bus.reg_out_en), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        invariants();
    endtask

    // One complete transaction from an IDLE negedge to the next IDLE negedge.
    task automatic do_transfer(input logic [NUM_REQ-1:0] drop_in_drive,
                               input logic [NUM_REQ-1:0] raise_in_latch,
                               input bit hold_req);
        int w;
        bit found;
        bit ok;
        logic [BUS_W-1:0] exp_data;
        logic [31:0] ow, os, od;
        w = 0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_v[(model_ptr + k) % NUM_REQ]) begin
                found = 1'b1;
                w = (model_ptr + k) % NUM_REQ;
            end
        end
        ok = (src_v[w] != dst_v[w]) && (src_v[w] < NUM_REGS) && (dst_v[w] < NUM_REGS);
        exp_data = regs[src_v[w]];
        ow = 32'd1 << w;
        os = 32'd1 << src_v[w];
        od = 32'd1 << dst_v[w];
        step();
        if (ok) begin
            check("drive_grant", 32'(bus.grant), ow);
            check("drive_out_en", 32'(bus.reg_out_en), os);
            check("drive_in_en", 32'(bus.reg_in_en), 32'd0);
            check("drive_done", 32'(bus.done), 32'd0);
            check("drive_busy", 32'(bus.busy), 32'd1);
            req_v = req_v & ~drop_in_drive;
            drive_reqs();
            step();
            check("latch_grant", 32'(bus.grant), ow);
            check("latch_out_en", 32'(bus.reg_out_en), os);
            check("latch_in_en", 32'(bus.reg_in_en), od);
            check("latch_done", 32'(bus.done), 32'd0);
            req_v = req_v | raise_in_latch;
            drive_reqs();
            step();
            check("ack_out_en", 32'(bus.reg_out_en), 32'd0);
            check("ack_in_en", 32'(bus.reg_in_en), 32'd0);
            check("ack_done", 32'(bus.done), ow);
            check("ack_err", 32'(bus.err), 32'd0);
            check("ack_grant", 32'(bus.grant), ow);
            check("ack_busy", 32'(bus.busy), 32'd1);
            check("dst_data", 32'(regs[dst_v[w]]), 32'(exp_data));
        end else begin
            check("rej_grant", 32'(bus.grant), ow);
            check("rej_out_en", 32'(bus.reg_out_en), 32'd0);
            check("rej_in_en", 32'(bus.reg_in_en), 32'd0);
            check("rej_done", 32'(bus.done), ow);
            check("rej_err", 32'(bus.err), ow);
            check("rej_busy", 32'(bus.busy), 32'd1);
        end
        model_ptr = (w + 1) % NUM_REQ;
        if (!hold_req) req_v[w] = 1'b0;
        drive_reqs();
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_grant", 32'(bus.grant), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_err", 32'(bus.err), 32'd0);
    endtask

    initial begin
        logic [BUS_W-1:0] saved4;
        req_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_v[i] = 0;
            dst_v[i] = 1;
        end
        model_ptr = 0;
        drive_reqs();

        // Reset state.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_out_en", 32'(bus.reg_out_en), 32'd0);
        check("rst_in_en", 32'(bus.reg_in_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);

        // Basic move reg2 -> reg5.
        req_v = 4'b0001; src_v[0] = 2; dst_v[0] = 5;
        drive_reqs();
        do_transfer('0, '0, 1'b0);
        check("reg5_holds_a5a5", 32'(regs[5]), 32'h0000_A5A5);

        // Reset asserted mid-LATCH, between clock edges.
        req_v = 4'b0010; src_v[1] = 1; dst_v[1] = 4;
        saved4 = regs[4];
        drive_reqs();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_en", 32'(bus.reg_out_en), 32'd0);
        check("midrst_in_en", 32'(bus.reg_in_en), 32'd0);
        check("midrst_grant", 32'(bus.grant), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        req_v = '0;
        drive_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        check("midrst_reg4_kept", 32'(regs[4]), 32'(saved4));

        // All four requesting continuously: order 0,1,2,3,0 starting from the reset pointer.
        req_v = 4'b1111;
        src_v[0] = 1; dst_v[0] = 2;
        src_v[1] = 3; dst_v[1] = 4;
        src_v[2] = 5; dst_v[2] = 6;
        src_v[3] = 7; dst_v[3] = 0;
        drive_reqs();
        for (int i = 0; i < 5; i++) do_transfer('0, '0, 1'b1);
        req_v = '0;

        // Rejected self-move.
        req_v = 4'b0010; src_v[1] = 3; dst_v[1] = 3;
        drive_reqs();
        do_transfer('0, '0, 1'b0);

        // req0 dropped during DRIVE, req2 raised during LATCH.
        req_v = 4'b0001; src_v[0] = 1; dst_v[0] = 6;
        src_v[2] = 3; dst_v[2] = 0;
        drive_reqs();
        do_transfer(4'b0001, 4'b0100, 1'b0);
        do_transfer('0, '0, 1'b0);

        // Back-to-back 7->0 and 0->7.
        req_v = 4'b1001;
        src_v[3] = 7; dst_v[3] = 0;
        src_v[0] = 0; dst_v[0] = 7;
        drive_reqs();
        do_transfer('0, '0, 1'b0);
        do_transfer('0, '0, 1'b0);

        // Randomized traffic; idle requesters may raise new requests between transfers.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_v[i] && ($urandom_range(0, 1) == 1)) begin
                    req_v[i] = 1'b1;
                    src_v[i] = $urandom_range(0, NUM_REGS - 1);
                    dst_v[i] = ($urandom_range(0, 5) == 0) ? src_v[i] : $urandom_range(0, NUM_REGS - 1);
                end
            end
            if (req_v == '0) begin
                req_v[0] = 1'b1;
                src_v[0] = $urandom_range(0, NUM_REGS - 1);
                dst_v[0] = $urandom_range(0, NUM_REGS - 1);
            end
            drive_reqs();
            do_transfer('0, '0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
